recebe_movimentos_uc: RTL and testbench

Control unit that sequences the move-reception datapath. It waits for a received byte and decodes the 3-bit move code. It hands each move to the motor sequencer with a level/pulse handshake, then triggers the serial ACK transmission and waits for it to complete. The session ends on code 000; a receive timeout raises an error. It sits between the reception datapath (UART RX/TX) and the cube-turning motor sequencer.

---
 rtl/recebe_movimentos_uc.sv | 143 ++++++++++++++
 tb/tb_recebe_movimentos_uc.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/recebe_movimentos_uc.sv
// Control unit for the move-reception datapath: waits for a byte, decodes the move code,
// hands it to the motor sequencer, then sends and waits for the serial ACK.
module recebe_movimentos_uc #(
  parameter int TIMEOUT_CICLOS = 50_000_000,
  parameter int CONT_W         = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              fim_recepcao,
  input  logic              fim_movimentos,
  input  logic [2:0]        movimento_in,
  input  logic              movimento_executado,
  input  logic              fim_transmissao,
  output logic              partida_serial,
  output logic              executa_movimento,
  output logic [2:0]        movimento,
  output logic [CONT_W-1:0] num_movimentos,
  output logic              pronto,
  output logic              erro_timeout,
  output logic [3:0]        db_estado
);

  localparam int TIMER_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CICLOS - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    ESPERA_BYTE = 4'd1,
    DECODIFICA  = 4'd2,
    EXECUTA     = 4'd3,
    ENVIA_ACK   = 4'd4,
    ESPERA_ACK  = 4'd5,
    FINAL       = 4'd6,
    ERRO        = 4'd7
  } estado_t;

  estado_t             estado_q, estado_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [2:0]          movimento_q, movimento_d;
  logic [CONT_W-1:0]   num_q, num_d;
  logic                fim_q, fim_d;
  logic                partida_q, partida_d;
  logic                executa_q, executa_d;
  logic                pronto_q, pronto_d;
  logic                erro_q, erro_d;

  always_comb begin
    estado_d    = estado_q;
    movimento_d = movimento_q;
    num_d       = num_q;
    fim_d       = fim_q;

    unique case (estado_q)
      INICIAL, ERRO: begin
        if (iniciar) begin
          estado_d = ESPERA_BYTE;
          num_d    = '0;
        end
      end
      ESPERA_BYTE: begin
        // a byte arriving on the last timer cycle still wins over the timeout
        if (fim_recepcao) begin
          estado_d    = DECODIFICA;
          movimento_d = movimento_in;
          fim_d       = fim_movimentos;
        end else if (timer_q == TIMER_MAX) begin
          estado_d = ERRO;
        end
      end
      DECODIFICA: begin
        if (fim_q) begin
          estado_d = FINAL;
        end else if (movimento_q == 3'b111) begin
          estado_d = ERRO;
        end else begin
          estado_d = EXECUTA;
          if (num_q != '1) num_d = num_q + CONT_W'(1);
        end
      end
      EXECUTA: begin
        if (movimento_executado) estado_d = ENVIA_ACK;
      end
      ENVIA_ACK: begin
        estado_d = ESPERA_ACK;
      end
      ESPERA_ACK: begin
        if (fim_transmissao) estado_d = ESPERA_BYTE;
      end
      FINAL: begin
        estado_d = INICIAL;
      end
      default: begin
        estado_d = INICIAL;
      end
    endcase

    // the timer only runs while staying in ESPERA_BYTE, so every entry starts from zero
    if (estado_q == ESPERA_BYTE && estado_d == ESPERA_BYTE) begin
      timer_d = timer_q + TIMER_W'(1);
    end else begin
      timer_d = '0;
    end

    partida_d = (estado_d == ENVIA_ACK);
    executa_d = (estado_d == EXECUTA);
    pronto_d  = (estado_d == FINAL);
    erro_d    = (estado_d == ERRO);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= INICIAL;
      timer_q     <= '0;
      movimento_q <= 3'b000;
      num_q       <= '0;
      fim_q       <= 1'b0;
      partida_q   <= 1'b0;
      executa_q   <= 1'b0;
      pronto_q    <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      timer_q     <= timer_d;
      movimento_q <= movimento_d;
      num_q       <= num_d;
      fim_q       <= fim_d;
      partida_q   <= partida_d;
      executa_q   <= executa_d;
      pronto_q    <= pronto_d;
      erro_q      <= erro_d;
    end
  end

  assign partida_serial    = partida_q;
  assign executa_movimento = executa_q;
  assign movimento         = movimento_q;
  assign num_movimentos    = num_q;
  assign pronto            = pronto_q;
  assign erro_timeout      = erro_q;
  assign db_estado         = estado_q;

endmodule

// File: tb/tb_recebe_movimentos_uc.sv
// Self-checking bench for recebe_movimentos_uc: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural session model.
module tb_recebe_movimentos_uc;

  localparam int TIMEOUT = 100;
  localparam int CW      = 8;
  localparam int NUM_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          iniciar = 1'b0;
  logic          fim_recepcao = 1'b0;
  logic          fim_movimentos = 1'b0;
  logic [2:0]    movimento_in = 3'b000;
  logic          movimento_executado = 1'b0;
  logic          fim_transmissao = 1'b0;
  logic          partida_serial;
  logic          executa_movimento;
  logic [2:0]    movimento;
  logic [CW-1:0] num_movimentos;
  logic          pronto;
  logic          erro_timeout;
  logic [3:0]    db_estado;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  recebe_movimentos_uc #(.TIMEOUT_CICLOS(TIMEOUT), .CONT_W(CW)) dut (
    .clock               (clock),
    .reset               (reset),
    .iniciar             (iniciar),
    .fim_recepcao        (fim_recepcao),
    .fim_movimentos      (fim_movimentos),
    .movimento_in        (movimento_in),
    .movimento_executado (movimento_executado),
    .fim_transmissao     (fim_transmissao),
    .partida_serial      (partida_serial),
    .executa_movimento   (executa_movimento),
    .movimento           (movimento),
    .num_movimentos      (num_movimentos),
    .pronto              (pronto),
    .erro_timeout        (erro_timeout),
    .db_estado           (db_estado)
  );

  initial forever #5 clock = ~clock;

  // Session model: phase numbers are the documented db_estado values.
  int m_phase = 0;
  int m_wait  = 0;
  int m_mov   = 0;
  bit m_end   = 1'b0;
  int m_moves = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_phase <= 0; m_wait <= 0; m_mov <= 0; m_end <= 1'b0; m_moves <= 0;
    end else begin
      if (m_phase == 0 || m_phase == 7) begin
        if (iniciar) begin m_phase <= 1; m_moves <= 0; m_wait <= 0; end
      end else if (m_phase == 1) begin
        if (fim_recepcao) begin
          m_phase <= 2; m_mov <= int'(movimento_in); m_end <= fim_movimentos;
        end else if (m_wait + 1 >= TIMEOUT) begin
          m_phase <= 7;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (m_phase == 2) begin
        if (m_end) m_phase <= 6;
        else if (m_mov == 7) m_phase <= 7;
        else begin
          m_phase <= 3;
          m_moves <= (m_moves < NUM_MAX) ? m_moves + 1 : NUM_MAX;
        end
      end else if (m_phase == 3) begin
        if (movimento_executado) m_phase <= 4;
      end else if (m_phase == 4) begin
        m_phase <= 5;
      end else if (m_phase == 5) begin
        if (fim_transmissao) begin m_phase <= 1; m_wait <= 0; end
      end else if (m_phase == 6) begin
        m_phase <= 0;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      check_output("m_db_estado", 32'(db_estado), m_phase);
      check_output("m_executa", 32'(executa_movimento), (m_phase == 3) ? 1 : 0);
      check_output("m_partida", 32'(partida_serial), (m_phase == 4) ? 1 : 0);
      check_output("m_pronto", 32'(pronto), (m_phase == 6) ? 1 : 0);
      check_output("m_erro", 32'(erro_timeout), (m_phase == 7) ? 1 : 0);
      check_output("m_movimento", 32'(movimento), m_mov);
      check_output("m_num", 32'(num_movimentos), m_moves);
    end
  end

  task automatic cycle();
    @(negedge clock);
    #1;
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1; cycle(); iniciar = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [2:0] code);
    movimento_in = code; fim_movimentos = (code == 3'b000); fim_recepcao = 1'b1;
    cycle();
    fim_recepcao = 1'b0; fim_movimentos = 1'b0;
  endtask

  task automatic send_move(input logic [2:0] code);
    apply_stimulus(code);
    cycle();
    movimento_executado = 1'b1; cycle(); movimento_executado = 1'b0;
    cycle();
    fim_transmissao = 1'b1; cycle(); fim_transmissao = 1'b0;
  endtask

  task automatic send_end();
    apply_stimulus(3'b000);
    check_output("end_decod", 32'(db_estado), 2);
    cycle();
    check_output("end_pronto", 32'(pronto), 1);
    check_output("end_final", 32'(db_estado), 6);
    cycle();
    check_output("end_pronto_drop", 32'(pronto), 0);
    check_output("end_inicial", 32'(db_estado), 0);
  endtask

  int quiet;

  initial begin
    repeat (3) cycle();
    cmp_en = 1'b1;
    check_output("rst_db", 32'(db_estado), 0);
    check_output("rst_outs", {27'd0, partida_serial, executa_movimento, pronto, erro_timeout, 1'b0}, 0);
    check_output("rst_mov", 32'(movimento), 0);
    check_output("rst_num", 32'(num_movimentos), 0);
    reset = 1'b1;
    cycle();

    pulse_iniciar();
    check_output("start_db", 32'(db_estado), 1);
    check_output("start_exec", 32'(executa_movimento), 0);

    apply_stimulus(3'b011);
    check_output("one_decod", 32'(db_estado), 2);
    check_output("one_exec_early", 32'(executa_movimento), 0);
    cycle();
    check_output("one_exec", 32'(executa_movimento), 1);
    check_output("one_mov", 32'(movimento), 3);
    check_output("one_num", 32'(num_movimentos), 1);
    cycle(); cycle();
    check_output("one_exec_hold", 32'(executa_movimento), 1);
    movimento_executado = 1'b1; cycle(); movimento_executado = 1'b0;
    check_output("one_partida", 32'(partida_serial), 1);
    cycle();
    check_output("one_partida_drop", 32'(partida_serial), 0);
    check_output("one_espera_ack", 32'(db_estado), 5);
    fim_transmissao = 1'b1; cycle(); fim_transmissao = 1'b0;
    check_output("one_back", 32'(db_estado), 1);
    send_end();
    check_output("one_num_hold", 32'(num_movimentos), 1);

    pulse_iniciar();
    check_output("seq_num_clear", 32'(num_movimentos), 0);
    send_move(3'b001);
    send_move(3'b110);
    check_output("seq_mov", 32'(movimento), 6);
    send_end();
    check_output("seq_num", 32'(num_movimentos), 2);

    pulse_iniciar();
    send_move(3'b100);
    apply_stimulus(3'b111);
    cycle();
    check_output("inv_erro", 32'(erro_timeout), 1);
    check_output("inv_db", 32'(db_estado), 7);
    check_output("inv_exec", 32'(executa_movimento), 0);
    check_output("inv_num", 32'(num_movimentos), 1);
    pulse_iniciar();
    check_output("erro_restart_db", 32'(db_estado), 1);
    check_output("erro_restart_num", 32'(num_movimentos), 0);

    repeat (TIMEOUT - 1) cycle();
    check_output("to_not_yet", 32'(erro_timeout), 0);
    cycle();
    check_output("to_erro", 32'(erro_timeout), 1);
    check_output("to_db", 32'(db_estado), 7);
    pulse_iniciar();
    repeat (TIMEOUT - 1) cycle();
    apply_stimulus(3'b010);
    check_output("late_byte_db", 32'(db_estado), 2);
    check_output("late_byte_erro", 32'(erro_timeout), 0);
    cycle();
    check_output("late_byte_exec", 32'(executa_movimento), 1);

    reset = 1'b0;
    #1;
    check_output("arst_exec", 32'(executa_movimento), 0);
    check_output("arst_db", 32'(db_estado), 0);
    check_output("arst_num", 32'(num_movimentos), 0);
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    pulse_iniciar();
    fim_transmissao = 1'b1; cycle(); fim_transmissao = 1'b0;
    check_output("spurious_tx", 32'(db_estado), 1);

    for (int i = 0; i < NUM_MAX + 5; i++) send_move(3'($urandom_range(1, 6)));
    check_output("sat_num", 32'(num_movimentos), NUM_MAX);

    quiet = 0;
    for (int i = 0; i < 4000; i++) begin
      if (quiet == 0 && $urandom_range(0, 199) == 0) quiet = $urandom_range(TIMEOUT - 5, TIMEOUT + 10);
      if (quiet > 0) begin
        quiet--;
        iniciar = 1'b0;
        fim_recepcao = 1'b0;
      end else begin
        iniciar = ($urandom_range(0, 15) == 0);
        fim_recepcao = ($urandom_range(0, 4) == 0);
      end
      movimento_in = 3'($urandom_range(0, 7));
      fim_movimentos = (movimento_in == 3'b000);
      movimento_executado = ($urandom_range(0, 3) == 0);
      fim_transmissao = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        cycle();
        reset = 1'b1;
      end else begin
        cycle();
      end
    end
    iniciar = 1'b0; fim_recepcao = 1'b0; movimento_executado = 1'b0; fim_transmissao = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
